wb_regfile: RTL
===============

Name: wb_regfile

Overview:
- Writeback-side consumer of the MEM/WB pipeline register.
- Each cycle it takes the MEM/WB outputs, selects the writeback result (memory data or ALU result), and commits it into a 32-entry register file.
- It serves two combinational read ports to the decode stage, with same-cycle write-to-read bypass.
- It provides a sequential clear sweep and performance counters for monitoring.

Parameters:
- DATA_W, 32, register and data width.
- ADDR_W, 5, register address width; the file holds 2**ADDR_W entries.
- COUNT_W, 32, width of each performance counter.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous reset, active low.
- regwrite_in  input  1  writeback enable from MEM/WB.
- memtoreg_in  input  1  1 = write memory data, 0 = write ALU result.
- readdata_in  input  DATA_W  memory load data from MEM/WB.
- ULAout_in  input  DATA_W  ALU result from MEM/WB.
- write_reg_in  input  ADDR_W  destination register.
- rs_addr  input  ADDR_W  read port A address.
- rt_addr  input  ADDR_W  read port B address.
- clear_req  input  1  request to start a clear sweep (single-cycle pulse or level).
- rs_data  output  DATA_W  read port A data.
- rt_data  output  DATA_W  read port B data.
- wb_result  output  DATA_W  selected writeback value (combinational).
- busy  output  1  clear sweep in progress.
- write_count  output  COUNT_W  committed writes.
- zero_write_count  output  COUNT_W  writes dropped because the destination was register 0.
- dropped_count  output  COUNT_W  writes dropped because a clear sweep was in progress.
- last_wr_reg  output  ADDR_W  destination of the last committed write.
- last_wr_data  output  DATA_W  data of the last committed write.

Behaviour:
- Clock and reset: one clock, clk. Reset reset_n is asynchronous and active-low.
- Reset values (reset_n low): every register-file entry = 0, state = IDLE, busy = 0, all counters = 0, last_wr_reg = 0, last_wr_data = 0. Reset takes effect immediately, including in the middle of a sweep.
- Writeback result: wb_result = memtoreg_in ? readdata_in : ULAout_in. Purely combinational; zero latency.
- A write is valid when regwrite_in = 1 and state = IDLE.
- Commit: valid write with write_reg_in != 0.
  - At the rising edge, entry[write_reg_in] <= wb_result.
  - write_count increments.
  - last_wr_reg and last_wr_data update.
- Register 0: valid write with write_reg_in == 0.
  - Array unchanged.
  - zero_write_count increments; write_count does not.
- During a sweep: regwrite_in = 1 while state = CLEAR.
  - Write dropped.
  - dropped_count increments; no other counter changes.
- Read ports (combinational):
  - Address 0 always returns 0.
  - Bypass: if a valid write targets the same nonzero address in the same cycle, the port returns wb_result.
  - Otherwise the port returns the array entry.
  - Bypass is disabled in CLEAR.
- State machine, IDLE → CLEAR: in IDLE, clear_req = 1 → CLEAR, clear_ptr <= 1.
- State machine, in CLEAR, each cycle:
  - entry[clear_ptr] <= 0 and clear_ptr increments.
  - When clear_ptr == 2**ADDR_W−1, that entry is cleared and the state returns to IDLE.
  - The sweep lasts 31 cycles for ADDR_W = 5.
- busy: equals (state == CLEAR), registered output.
- clear_req in CLEAR: ignored; the sweep does not restart.
- Reads during CLEAR: return current array contents (partially cleared). Decode stalls on busy.
- Simultaneous events:
  - clear_req and regwrite_in in the same IDLE cycle: the write commits in that cycle, then the sweep begins next cycle and also clears that entry.
  - Two read ports on the same address: both return identical data.
- Counter width: all counters wrap modulo 2**COUNT_W, with no saturation.

Decomposition:
- Shared package wb_pkg holds:
  - rf_state_t enum: IDLE = 1'b0, CLEAR = 1'b1.
  - DATA_W and ADDR_W defaults.
  - REG_ZERO constant = 0.
- One sub-module, wb_perf_counters, holds the three counters and last_wr_* tracking. It is driven by commit, zero_write and dropped strobes.
- The array, bypass and FSM stay in wb_regfile.

Test Plan:
1. Reset: drive reset_n low, then release → rs_data = rt_data = 0 for all addresses; busy = 0; all counters = 0.
2. ALU write with bypass: regwrite = 1, memtoreg = 0, ULAout = 0xDEADBEEF, write_reg = 5, rs_addr = 5.
   - Same cycle: rs_data = 0xDEADBEEF.
   - After the edge: rs_data is still 0xDEADBEEF; write_count = 1; last_wr_reg = 5.
3. Memory-path select: memtoreg = 1, readdata = 0x12345678, ULAout = 0xFFFFFFFF, write_reg = 7 → rt_addr = 7 reads 0x12345678.
4. Register 0 write: write_reg = 0, ULAout = 0x1 → rs_addr = 0 reads 0; zero_write_count = 1; write_count unchanged.
5. Clear sweep: populate $1 = 0xA and $31 = 0xB, then pulse clear_req.
   - busy is high for exactly 31 cycles.
   - A writeback to $3 mid-sweep is dropped: dropped_count = 1.
   - Afterwards $1, $3 and $31 all read 0.
6. Reset mid-sweep: drop reset_n on sweep cycle 10 → busy = 0 immediately; state is IDLE and a clear_req pulse restarts a full 31-cycle sweep; all entries read 0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and defaults for the writeback-side register file slice.
package wb_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 5;
  localparam int DEF_COUNT_W = 32;
  localparam int REG_ZERO    = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rf_state_t;

endpackage

// File: rtl/wb_perf_counters.sv
// Monitoring counters for the register file: commits, register-0 writes and sweep drops,
// plus a record of the most recent committed write.
module wb_perf_counters
  import wb_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int COUNT_W = DEF_COUNT_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               commit,
  input  logic               zero_write,
  input  logic               dropped,
  input  logic [ADDR_W-1:0]  wr_reg,
  input  logic [DATA_W-1:0]  wr_data,
  output logic [COUNT_W-1:0] write_count,
  output logic [COUNT_W-1:0] zero_write_count,
  output logic [COUNT_W-1:0] dropped_count,
  output logic [ADDR_W-1:0]  last_wr_reg,
  output logic [DATA_W-1:0]  last_wr_data
);

  // Counters wrap naturally at their width; there is no saturation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      write_count      <= '0;
      zero_write_count <= '0;
      dropped_count    <= '0;
      last_wr_reg      <= '0;
      last_wr_data     <= '0;
    end else begin
      if (commit) begin
        write_count  <= write_count + 1'b1;
        last_wr_reg  <= wr_reg;
        last_wr_data <= wr_data;
      end
      if (zero_write) zero_write_count <= zero_write_count + 1'b1;
      if (dropped)    dropped_count    <= dropped_count + 1'b1;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage register file: selects the MEM/WB result, commits it, serves two
// bypassed read ports and runs a sequential clear sweep over entries 1..N-1.
module wb_regfile
  import wb_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int COUNT_W = DEF_COUNT_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               regwrite_in,
  input  logic               memtoreg_in,
  input  logic [DATA_W-1:0]  readdata_in,
  input  logic [DATA_W-1:0]  ULAout_in,
  input  logic [ADDR_W-1:0]  write_reg_in,
  input  logic [ADDR_W-1:0]  rs_addr,
  input  logic [ADDR_W-1:0]  rt_addr,
  input  logic               clear_req,
  output logic [DATA_W-1:0]  rs_data,
  output logic [DATA_W-1:0]  rt_data,
  output logic [DATA_W-1:0]  wb_result,
  output logic               busy,
  output logic [COUNT_W-1:0] write_count,
  output logic [COUNT_W-1:0] zero_write_count,
  output logic [COUNT_W-1:0] dropped_count,
  output logic [ADDR_W-1:0]  last_wr_reg,
  output logic [DATA_W-1:0]  last_wr_data
);

  localparam int                NUM_REGS  = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_REG  = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  rf_state_t         state, next_state;
  logic [ADDR_W-1:0] clear_ptr;
  logic [DATA_W-1:0] regs [NUM_REGS];

  logic wr_valid;
  logic commit;
  logic zero_write;
  logic dropped;

  assign wb_result  = memtoreg_in ? readdata_in : ULAout_in;
  assign wr_valid   = regwrite_in && (state == IDLE);
  assign commit     = wr_valid && (write_reg_in != ZERO_ADDR);
  assign zero_write = wr_valid && (write_reg_in == ZERO_ADDR);
  assign dropped    = regwrite_in && (state == CLEAR);
  assign busy       = (state == CLEAR);

  // commit already implies IDLE, so the bypass is naturally off during a sweep.
  assign rs_data = (rs_addr == ZERO_ADDR)                ? '0        :
                   (commit && (write_reg_in == rs_addr)) ? wb_result :
                                                           regs[rs_addr];
  assign rt_data = (rt_addr == ZERO_ADDR)                ? '0        :
                   (commit && (write_reg_in == rt_addr)) ? wb_result :
                                                           regs[rt_addr];

  always_comb begin
    // NOTE: next_state gets a default before the case so no path can infer a latch.
    next_state = state;
    case (state)
      IDLE:    if (clear_req) next_state = CLEAR;
      CLEAR:   if (clear_ptr == LAST_REG) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // clear_ptr is preloaded with 1 while idle so the sweep starts there on entry.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      state     <= IDLE;
      clear_ptr <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE) clear_ptr <= ADDR_W'(1);
      else               clear_ptr <= clear_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the array has a real reset because it must read back as zero; this rules out a RAM macro.
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (state == CLEAR) begin
      regs[clear_ptr] <= '0;
    end else if (commit) begin
      regs[write_reg_in] <= wb_result;
    end
  end

  wb_perf_counters #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .COUNT_W (COUNT_W)
  ) u_perf (
    .clk              (clk),
    .reset_n          (reset_n),
    .commit           (commit),
    .zero_write       (zero_write),
    .dropped          (dropped),
    .wr_reg           (write_reg_in),
    .wr_data          (wb_result),
    .write_count      (write_count),
    .zero_write_count (zero_write_count),
    .dropped_count    (dropped_count),
    .last_wr_reg      (last_wr_reg),
    .last_wr_data     (last_wr_data)
  );

endmodule
